// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and group generate/propagate; stage 2 resolves carries and registers the result.
module cla_adder_pipe #(
  parameter int WIDTH      = 8,
  parameter int GROUP_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          carry_in,
  input  logic                          sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              sum,
  output logic                          carry_out,
  output logic                          overflow,
  output logic [WIDTH/GROUP_SIZE-1:0]   grp_g,
  output logic [WIDTH/GROUP_SIZE-1:0]   grp_p
);

  localparam int NG = WIDTH / GROUP_SIZE;

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH % GROUP_SIZE) != 0 ||
      !(GROUP_SIZE == 2 || GROUP_SIZE == 4 || GROUP_SIZE == 8)) begin : g_param_check
    $error("cla_adder_pipe: illegal WIDTH/GROUP_SIZE combination");
  end

  // Collapse one group's bit g/p into its group {G, P}, scanning from LSB to MSB.
  function automatic logic [1:0] group_gp(input logic [GROUP_SIZE-1:0] g_bits,
                                          input logic [GROUP_SIZE-1:0] p_bits);
    logic g_acc;
    logic p_acc;
    g_acc = 1'b0;
    p_acc = 1'b1;
    for (int j = 0; j < GROUP_SIZE; j++) begin
      g_acc = g_bits[j] | (p_bits[j] & g_acc);
      p_acc = p_acc & p_bits[j];
    end
    return {g_acc, p_acc};
  endfunction

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_cin_eff;
  logic [NG-1:0]    w_grp_g;
  logic [NG-1:0]    w_grp_p;

  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | carry_in;
  assign w_p       = a ^ w_b_eff;
  assign w_g       = a & w_b_eff;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    assign {w_grp_g[gi], w_grp_p[gi]} =
      group_gp(w_g[gi*GROUP_SIZE +: GROUP_SIZE], w_p[gi*GROUP_SIZE +: GROUP_SIZE]);
  end

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_p;
  logic [WIDTH-1:0] r_s1_g;
  logic             r_s1_cin;
  logic [NG-1:0]    r_s1_grp_g;
  logic [NG-1:0]    r_s1_grp_p;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;
  logic [NG-1:0]    r_grp_g;
  logic [NG-1:0]    r_grp_p;

  logic             w_adv2;
  logic             w_accept;
  logic             w_s1_move;

  assign w_adv2    = ~r_out_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_adv2;
  assign w_accept  = in_valid & in_ready;
  assign w_s1_move = r_s1_valid & w_adv2;

  // Group carries ripple across NG groups, then each group ripples at most GROUP_SIZE-1 bits.
  logic [NG:0]    w_c_grp;
  logic [WIDTH:0] w_c;

  always_comb begin
    w_c_grp    = '0;
    w_c        = '0;
    w_c_grp[0] = r_s1_cin;
    for (int k = 0; k < NG; k++) begin
      w_c_grp[k+1] = r_s1_grp_g[k] | (r_s1_grp_p[k] & w_c_grp[k]);
    end
    for (int k = 0; k < NG; k++) begin
      w_c[k*GROUP_SIZE] = w_c_grp[k];
      for (int j = 0; j < GROUP_SIZE - 1; j++) begin
        w_c[k*GROUP_SIZE+j+1] = r_s1_g[k*GROUP_SIZE+j] |
                                (r_s1_p[k*GROUP_SIZE+j] & w_c[k*GROUP_SIZE+j]);
      end
    end
    w_c[WIDTH] = w_c_grp[NG];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_grp_g <= '0;
      r_s1_grp_p <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_p     <= w_p;
      r_s1_g     <= w_g;
      r_s1_cin   <= w_cin_eff;
      r_s1_grp_g <= w_grp_g;
      r_s1_grp_p <= w_grp_p;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_grp_g     <= '0;
      r_grp_p     <= '0;
    end else if (w_s1_move) begin
      r_out_valid <= 1'b1;
      r_sum       <= r_s1_p ^ w_c[WIDTH-1:0];
      r_carry_out <= w_c[WIDTH];
      r_overflow  <= w_c[WIDTH] ^ w_c[WIDTH-1];
      r_grp_g     <= r_s1_grp_g;
      r_grp_p     <= r_s1_grp_p;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign grp_g     = r_grp_g;
  assign grp_p     = r_grp_p;

endmodule
